mini_cpu_seq: RTL
=================

MINI_CPU_SEQ -- requirements
Module: mini_cpu_seq

Interface
REQ-001 Parameter DATA_W, default 16: register, ALU and result width.
REQ-002 Parameter ADDR_W, default 4: register-address width; register file holds 2**ADDR_W entries.
REQ-003 Parameter IMM_W, default 6: immediate magnitude width; operand field width F = IMM_W+1, and F SHALL be >= ADDR_W.
REQ-004 Parameter CNT_W, default 8: retired-instruction counter width.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port ligar, input, 1: power push-button, active-low, asynchronous to clk.
REQ-008 Port enviar, input, 1: submit push-button, active-low, asynchronous to clk.
REQ-009 Port opcode, input, 3: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 DISPLAY.
REQ-010 Port addr1, input, ADDR_W: destination register (DISPLAY: source).
REQ-011 Port addr2, input, ADDR_W: first source register.
REQ-012 Port addr3OuImm, input, F: addr3 = bits [F-1 -: ADDR_W]; immediate sign = bit F-1, magnitude = bits [IMM_W-1:0].
REQ-013 Port result, output, DATA_W: last shown value.
REQ-014 Port on, output, 1: high while in OFF.
REQ-015 Port estado, output, 3: current state code.
REQ-016 Port busy, output, 1: high in DECODE..STORE.
REQ-017 Port done, output, 1: one-cycle pulse on instruction retirement.
REQ-018 Port ovf, output, 1: signed overflow of the last retired arithmetic instruction.
REQ-019 Port instr_count, output, CNT_W: retired instructions, wraps modulo 2**CNT_W.

Function
REQ-020 ligar and enviar SHALL each pass a 2-flop synchronizer; a press event SHALL be the synchronized signal rising 0->1 (button release).
REQ-021 States: OFF=000, FETCH=001, DECODE=010, READ=011, CALC=100, SHOW=101, STORE=110; estado SHALL equal the state register.
REQ-022 ligar event in OFF -> FETCH; in any other state -> OFF, aborting the in-flight instruction with no register write, result/ovf/instr_count unchanged; ligar has priority over all other transitions.
REQ-023 enviar event in FETCH SHALL latch opcode, addr1, addr2 and addr3OuImm, then -> DECODE; enviar events in any other state SHALL be discarded, not queued.
REQ-024 DECODE->READ->CALC->SHOW->STORE->FETCH, one cycle each; enviar event to done pulse = 6 clk cycles.
REQ-025 Immediate SHALL be sign-magnitude, converted to DATA_W two's complement (sign=1, magnitude 0 -> 0).
REQ-026 LOAD: R[addr1] <= imm.
REQ-027 ADD: R[addr1] <= R[addr2]+R[addr3]; ADDI: R[addr1] <= R[addr2]+imm.
REQ-028 SUB: R[addr1] <= R[addr2]-R[addr3]; SUBI: R[addr1] <= R[addr2]-imm.
REQ-029 MUL: R[addr1] <= low DATA_W bits of signed R[addr2]*R[addr3]; ovf=1 when the full 2*DATA_W product does not fit signed DATA_W.
REQ-030 Arithmetic SHALL wrap modulo 2**DATA_W; ovf for ADD/ADDI/SUB/SUBI SHALL be two's-complement overflow; LOAD, CLEAR and DISPLAY SHALL clear ovf.
REQ-031 CLEAR: all registers and result <= 0.
REQ-032 DISPLAY: result <= R[addr1]; no register write.
REQ-033 Operands SHALL be read in READ, computed in CALC, result updated on the SHOW->STORE edge, register written and ovf updated on the STORE->FETCH edge.
REQ-034 With addr1 equal to addr2 or addr3, sources SHALL be the pre-write values.
REQ-035 On the STORE->FETCH edge: done SHALL be 1 for exactly one cycle and instr_count SHALL increment.

Reset
REQ-036 rst_n low SHALL immediately force: state OFF, on=1, estado=000, result=0, busy=0, done=0, ovf=0, instr_count=0, all registers 0, synchronizers to 1 (released).
REQ-037 rst_n assertion mid-instruction SHALL abort it with no register write; operation resumes only after a ligar event.

Verification
REQ-038 Reset, ligar press/release -> on falls, estado=001; enviar in OFF beforehand -> no effect.
REQ-039 LOAD R1=5 (field 0000101), LOAD R2=-3 (field 1000011), ADD R3=R1+R2 -> result=0x0002, done pulse 6 cycles after each release, instr_count=3.
REQ-040 R1=0x7FFF via ADDI chain, ADDI R1,R1,+1 -> result=0x8000, ovf=1; then DISPLAY R1 -> result=0x8000, ovf=0.
REQ-041 MUL 0x0100*0x0100 -> result=0x0000, ovf=1; MUL 3*-4 -> 0xFFF4, ovf=0.
REQ-042 ligar event while estado=100 -> OFF, destination register unchanged, no done, instr_count unchanged.
REQ-043 CLEAR after loads -> all registers and result 0; enviar events during busy ignored; 256 instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/mini_cpu_seq.sv
// Button-driven multi-cycle CPU: a submitted instruction walks FETCH..STORE and retires
// one register-file write per instruction. The power button toggles between OFF and running.
module mini_cpu_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int IMM_W  = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ligar,
    input  logic              enviar,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [IMM_W:0]    addr3OuImm,
    output logic [DATA_W-1:0] result,
    output logic              on,
    output logic [2:0]        estado,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [CNT_W-1:0]  instr_count
);
    localparam int F    = IMM_W + 1;
    localparam int NREG = 2 ** ADDR_W;
    localparam int M    = DATA_W - 1;

    localparam logic [2:0] S_OFF    = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_READ   = 3'b011;
    localparam logic [2:0] S_CALC   = 3'b100;
    localparam logic [2:0] S_SHOW   = 3'b101;
    localparam logic [2:0] S_STORE  = 3'b110;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    logic [1:0]        ligar_sync_q, enviar_sync_q;
    logic              ligar_prev_q, enviar_prev_q;
    logic              ligar_evt, enviar_evt;
    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] a1_q, a2_q, a3;
    logic [F-1:0]      f_q;
    logic [DATA_W-1:0] opa_q, opb_q, alu_q, alu_d, result_q;
    logic [DATA_W-1:0] imm_mag, imm, sum, diff;
    logic [2*DATA_W-1:0] prod;
    logic              alu_ovf_q, alu_ovf_d, ovf_q, done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rf_we, rf_clr, uses_imm;
    logic [DATA_W-1:0] rf_rd [NREG];

    // Buttons are active-low; the event is the release (synchronized 0->1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ligar_sync_q  <= 2'b11;
            enviar_sync_q <= 2'b11;
            ligar_prev_q  <= 1'b1;
            enviar_prev_q <= 1'b1;
        end else begin
            ligar_sync_q  <= {ligar_sync_q[0], ligar};
            enviar_sync_q <= {enviar_sync_q[0], enviar};
            ligar_prev_q  <= ligar_sync_q[1];
            enviar_prev_q <= enviar_sync_q[1];
        end
    end
    assign ligar_evt  = ligar_sync_q[1] & ~ligar_prev_q;
    assign enviar_evt = enviar_sync_q[1] & ~enviar_prev_q;

    always_comb begin
        state_d = state_q;
        if (ligar_evt) begin
            state_d = (state_q == S_OFF) ? S_FETCH : S_OFF;
        end else begin
            case (state_q)
                S_FETCH:  if (enviar_evt) state_d = S_DECODE;
                S_DECODE: state_d = S_READ;
                S_READ:   state_d = S_CALC;
                S_CALC:   state_d = S_SHOW;
                S_SHOW:   state_d = S_STORE;
                S_STORE:  state_d = S_FETCH;
                default:  state_d = S_OFF;
            endcase
        end
    end

    // Sign-magnitude immediate; a negative zero collapses to 0 naturally.
    assign a3       = f_q[F-1 -: ADDR_W];
    assign imm_mag  = {{(DATA_W-IMM_W){1'b0}}, f_q[IMM_W-1:0]};
    assign imm      = f_q[F-1] ? (~imm_mag + DATA_W'(1)) : imm_mag;
    assign uses_imm = (op_q == OP_LOAD) || (op_q == OP_ADDI) || (op_q == OP_SUBI);
    assign sum      = opa_q + opb_q;
    assign diff     = opa_q - opb_q;
    assign prod     = $signed({{DATA_W{opa_q[M]}}, opa_q}) * $signed({{DATA_W{opb_q[M]}}, opb_q});

    always_comb begin
        alu_d     = '0;
        alu_ovf_d = 1'b0;
        case (op_q)
            OP_LOAD: alu_d = opb_q;
            OP_ADD, OP_ADDI: begin
                alu_d     = sum;
                alu_ovf_d = (opa_q[M] == opb_q[M]) && (sum[M] != opa_q[M]);
            end
            OP_SUB, OP_SUBI: begin
                alu_d     = diff;
                alu_ovf_d = (opa_q[M] != opb_q[M]) && (diff[M] != opa_q[M]);
            end
            OP_MUL: begin
                alu_d     = prod[DATA_W-1:0];
                alu_ovf_d = !((&prod[2*DATA_W-1:M]) || (~|prod[2*DATA_W-1:M]));
            end
            OP_DISPLAY: alu_d = opa_q;
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            op_q      <= '0;
            a1_q      <= '0;
            a2_q      <= '0;
            f_q       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            alu_q     <= '0;
            alu_ovf_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (!ligar_evt) begin
                case (state_q)
                    S_FETCH: if (enviar_evt) begin
                        op_q <= opcode;
                        a1_q <= addr1;
                        a2_q <= addr2;
                        f_q  <= addr3OuImm;
                    end
                    S_READ: begin
                        opa_q <= (op_q == OP_DISPLAY) ? rf_rd[a1_q] : rf_rd[a2_q];
                        opb_q <= uses_imm ? imm : rf_rd[a3];
                    end
                    S_CALC: begin
                        alu_q     <= alu_d;
                        alu_ovf_q <= alu_ovf_d;
                    end
                    S_SHOW: result_q <= alu_q;
                    S_STORE: begin
                        ovf_q  <= alu_ovf_q;
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Writes happen only on an unaborted STORE->FETCH edge.
    assign rf_we  = (state_q == S_STORE) && !ligar_evt && (op_q != OP_DISPLAY) && (op_q != OP_CLEAR);
    assign rf_clr = (state_q == S_STORE) && !ligar_evt && (op_q == OP_CLEAR);

    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (rf_clr) begin
                r_q <= '0;
            end else if (rf_we && (a1_q == ADDR_W'(gi))) begin
                r_q <= alu_q;
            end
        end
        assign rf_rd[gi] = r_q;
    end

    assign result      = result_q;
    assign on          = (state_q == S_OFF);
    assign estado      = state_q;
    assign busy        = (state_q >= S_DECODE) && (state_q <= S_STORE);
    assign done        = done_q;
    assign ovf         = ovf_q;
    assign instr_count = cnt_q;
endmodule
